// File: rtl/neuron_pkg.sv
// Shared Q16.16 definitions for the neuron core and its input-current path:
// format constants, accumulator state encoding and the saturating adder.
package neuron_pkg;

   localparam int Q_FRAC_BITS = 16;
   localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } acc_state_e;

   // Q16.16 add with a 33-bit intermediate; clamps instead of wrapping.
   function automatic logic signed [31:0] q_sat_add(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
      logic [32:0] sum;
      sum = {a[31], a} + {b[31], b};
      if (sum[32] != sum[31]) begin
         q_sat_add = sum[32] ? Q_MIN : Q_MAX;
      end else begin
         q_sat_add = sum[31:0];
      end
   endfunction

endpackage

// File: rtl/synaptic_current_accumulator_if.sv
// Spike-event input and neuron-current output bundle of the accumulator.
// master: the accumulator itself; slave: the router/neuron-core side.
interface synaptic_current_accumulator_if;
   logic        SPIKE_VALID;
   logic [31:0] SPIKE_WEIGHT;
   logic        SPIKE_READY;
   logic        TIMESTEP;
   logic [31:0] I;
   logic        I_VALID;
   logic        OVERRUN;

   modport master (
      input  SPIKE_VALID, SPIKE_WEIGHT, TIMESTEP,
      output SPIKE_READY, I, I_VALID, OVERRUN
   );

   modport slave (
      output SPIKE_VALID, SPIKE_WEIGHT, TIMESTEP,
      input  SPIKE_READY, I, I_VALID, OVERRUN
   );
endinterface

// File: rtl/spike_event_fifo.sv
// Synchronous DEPTH x WIDTH event FIFO. The read port is registered: a pop
// loads the head word into pop_data_o, which the accumulator uses directly
// as its operand register.
module spike_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = rd_data_q;

   // Storage and read register carry no reset so they map onto block RAM.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
      if (do_pop) begin
         rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/synaptic_current_accumulator.sv
// Sums weighted spike events over a neuron timestep with saturating Q16.16
// arithmetic and hands the total to the neuron core with a one-cycle strobe.
// Optional macro SYNAPSE_DECAY_EN: the accumulator leaks by acc >>> DECAY_SHIFT
// at each commit instead of clearing to zero.
module synaptic_current_accumulator
   import neuron_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int DECAY_SHIFT = 1
) (
   input  logic                           CLK,
   input  logic                           RESET,
   synaptic_current_accumulator_if.master sca
);

   localparam int AW = $clog2(DEPTH);

   // Reject configurations the pointer arithmetic and the leak shift cannot support.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (DECAY_SHIFT < 0 || DECAY_SHIFT > 31) begin : g_bad_shift
      $error("DECAY_SHIFT must lie in 0..31");
   end

   acc_state_e         state_q, state_d;
   logic signed [31:0] acc_q, acc_d;
   logic signed [31:0] i_q, i_d;
   logic               i_valid_q, i_valid_d;
   logic               overrun_q, overrun_d;
   logic               pending_q;
   logic [AW:0]        drain_cnt_q, drain_cnt_d;

   logic               fifo_full;
   logic               fifo_empty;
   logic [AW:0]        fifo_count;
   logic [31:0]        operand;
   logic               push;
   logic               pop_req;
   logic               pop;
   logic [AW:0]        occ_after;

   assign sca.SPIKE_READY = !fifo_full && !RESET;
   assign push            = sca.SPIKE_VALID && sca.SPIKE_READY;
   // A pop needs the add unit idle; during DRAIN only snapshotted events qualify.
   assign pop_req   = !pending_q &&
                      ((state_q == ACCUM) || (state_q == DRAIN && drain_cnt_q != '0));
   assign pop       = pop_req && !fifo_empty;
   // Occupancy after this edge, counting a same-cycle push and pop.
   assign occ_after = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

   spike_event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .CLK         (CLK),
      .RESET       (RESET),
      .push_i      (push),
      .push_data_i (sca.SPIKE_WEIGHT),
      .pop_i       (pop),
      .pop_data_o  (operand),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Next-state logic: add stage, timestep snapshot, drain countdown and commit.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      i_d         = i_q;
      i_valid_d   = 1'b0;
      overrun_d   = overrun_q;
      drain_cnt_d = drain_cnt_q;

      if (pending_q) begin
         acc_d = q_sat_add(acc_q, operand);
      end

      case (state_q)
         ACCUM: begin
            if (sca.TIMESTEP) begin
               drain_cnt_d = occ_after;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (pop) begin
               drain_cnt_d = drain_cnt_q - 1'b1;
            end
            if (sca.TIMESTEP) begin
               overrun_d = 1'b1;
            end
            if (drain_cnt_q == '0 && !pending_q) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            i_d       = acc_q;
            i_valid_d = 1'b1;
`ifdef SYNAPSE_DECAY_EN
            acc_d     = acc_q - (acc_q >>> DECAY_SHIFT);
`else
            acc_d     = '0;
`endif
            if (sca.TIMESTEP) begin
               overrun_d = 1'b1;
            end
            state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   // State registers; reset discards any in-flight operand.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         i_q         <= '0;
         i_valid_q   <= 1'b0;
         overrun_q   <= 1'b0;
         pending_q   <= 1'b0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         i_q         <= i_d;
         i_valid_q   <= i_valid_d;
         overrun_q   <= overrun_d;
         pending_q   <= pop;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign sca.I       = i_q;
   assign sca.I_VALID = i_valid_q;
   assign sca.OVERRUN = overrun_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Directed bench: stimulus pushes expected currents into a queue at each
// TIMESTEP; an independent monitor compares them whenever I_VALID fires.
module tb_synaptic_current_accumulator;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] exp_q [$];
   logic        prev_valid;

   synaptic_current_accumulator_if sca ();

   synaptic_current_accumulator #(
      .DEPTH       (4),
      .DECAY_SHIFT (1)
   ) dut (
      .CLK   (clk),
      .RESET (rst),
      .sca   (sca)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_event(input logic [31:0] w);
      int   waited;
      logic took;
      waited = 0;
      sca.SPIKE_VALID  = 1'b1;
      sca.SPIKE_WEIGHT = w;
      do begin
         took = sca.SPIKE_READY;
         tick();
         waited++;
      end while (!took && waited < 100);
      sca.SPIKE_VALID = 1'b0;
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: got ready=0 expected ready=1 within 100 cycles");
      end else begin
         $display("push: weight=%h", w);
      end
   endtask

   task automatic pulse_timestep(input logic [31:0] exp);
      exp_q.push_back(exp);
      sca.TIMESTEP = 1'b1;
      tick();
      sca.TIMESTEP = 1'b0;
   endtask

   task automatic wait_commit();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL commit_timeout: got no I_VALID expected %h", exp_q[0]);
         exp_q.delete();
      end
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check("reset_ready", 32'(sca.SPIKE_READY), 32'd0);
      check("reset_I", sca.I, 32'h0);
      check("reset_ivalid", 32'(sca.I_VALID), 32'd0);
      check("reset_overrun", 32'(sca.OVERRUN), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_reset_ready", 32'(sca.SPIKE_READY), 32'd1);
   endtask

   // Monitor: every I_VALID strobe consumes one expected current.
   initial begin
      logic [31:0] e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (sca.I_VALID) begin
            check("ivalid_one_cycle", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: got I=%h expected no commit", sca.I);
            end else begin
               e = exp_q.pop_front();
               $display("commit: I=%h expected=%h", sca.I, e);
               check("commit_I", sca.I, e);
            end
         end
         prev_valid = sca.I_VALID;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   accepted;
      logic saw_low;
      logic r;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      sca.SPIKE_VALID  = 1'b0;
      sca.SPIKE_WEIGHT = '0;
      sca.TIMESTEP     = 1'b0;

      do_reset();

      // Basic sum: 1.0 + 2.5 - 0.5 = 3.0
      push_event(32'h0001_0000);
      push_event(32'h0002_8000);
      push_event(32'hFFFF_8000);
      repeat (8) tick();
      pulse_timestep(32'h0003_0000);
      wait_commit();
`ifdef SYNAPSE_DECAY_EN
      pulse_timestep(32'h0001_8000);
`else
      pulse_timestep(32'h0000_0000);
`endif
      wait_commit();

      // Positive and negative saturation.
      do_reset();
      push_event(32'h7FFF_0000);
      push_event(32'h7FFF_0000);
      pulse_timestep(32'h7FFF_FFFF);
      wait_commit();
      do_reset();
      push_event(32'h8001_0000);
      push_event(32'h8001_0000);
      pulse_timestep(32'h8000_0000);
      wait_commit();

      // Backpressure: continuous offers outrun the 1-per-2-cycle adder.
      do_reset();
      accepted = 0;
      saw_low  = 1'b0;
      sca.SPIKE_VALID  = 1'b1;
      sca.SPIKE_WEIGHT = 32'h0001_0000;
      for (int k = 0; k < 20; k++) begin
         r = sca.SPIKE_READY;
         if (r) accepted++;
         else saw_low = 1'b1;
         tick();
      end
      sca.SPIKE_VALID = 1'b0;
      $display("backpressure: accepted=%0d", accepted);
      check("bp_ready_dropped", 32'(saw_low), 32'd1);
      pulse_timestep(32'(accepted) << 16);
      wait_commit();

      // Timestep boundary: third push shares the TIMESTEP cycle, two more land in DRAIN.
      do_reset();
      push_event(32'h0001_0000);
      push_event(32'h0001_0000);
      exp_q.push_back(32'h0003_0000);
      sca.SPIKE_VALID  = 1'b1;
      sca.SPIKE_WEIGHT = 32'h0001_0000;
      sca.TIMESTEP     = 1'b1;
      r = sca.SPIKE_READY;
      tick();
      sca.SPIKE_VALID = 1'b0;
      sca.TIMESTEP    = 1'b0;
      check("boundary_push_ready", 32'(r), 32'd1);
      push_event(32'h0001_0000);
      push_event(32'h0001_0000);
      wait_commit();
`ifdef SYNAPSE_DECAY_EN
      pulse_timestep(32'h0003_8000);
`else
      pulse_timestep(32'h0002_0000);
`endif
      wait_commit();

      // Leak: 4.0 then either half of it or zero.
      do_reset();
      push_event(32'h0004_0000);
      pulse_timestep(32'h0004_0000);
      wait_commit();
`ifdef SYNAPSE_DECAY_EN
      pulse_timestep(32'h0002_0000);
`else
      pulse_timestep(32'h0000_0000);
`endif
      wait_commit();
      check("no_spurious_overrun", 32'(sca.OVERRUN), 32'd0);

      // Overrun: a second TIMESTEP while draining.
      do_reset();
      push_event(32'h0001_0000);
      push_event(32'h0002_0000);
      exp_q.push_back(32'h0003_0000);
      sca.TIMESTEP = 1'b1;
      tick();
      tick();
      sca.TIMESTEP = 1'b0;
      wait_commit();
      check("overrun_set", 32'(sca.OVERRUN), 32'd1);
      repeat (3) tick();
      check("overrun_sticky", 32'(sca.OVERRUN), 32'd1);

      // Reset with events queued discards them.
      push_event(32'h0001_0000);
      push_event(32'h0001_0000);
      push_event(32'h0001_0000);
      do_reset();
      pulse_timestep(32'h0000_0000);
      wait_commit();

      repeat (5) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
